vending_change_dispenser: RTL and testbench
===========================================

# vending_change_dispenser

Coin-return engine for the vending machine: accepts a change amount from the vending controller and ejects it as discrete coins through a hopper handshake. Uses a greedy largest-denomination-first algorithm over three denominations and tracks per-denomination coin inventory. When inventory cannot cover the full amount, it reports the undispensed remainder. Sits between the vending controller's change output and the coin hopper driver.

## Interface
- DEN_HI, 10, high denomination value (8-bit)
- DEN_MID, 5, middle denomination value
- DEN_LO, 1, low denomination value; must be 1
- INV_INIT, 20, per-denomination inventory loaded at reset
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- change_valid  in  1  change request; sampled only in IDLE
- change_amount  in  8  amount to return, captured with change_valid
- busy  out  1  high from the cycle after acceptance until done
- coin_req  out  1  hopper eject request, four-phase
- coin_sel  out  2  denomination to eject: 00 LO, 01 MID, 10 HI; held stable while coin_req=1
- coin_ack  in  1  hopper eject acknowledge
- done  out  1  one-cycle completion pulse
- shortfall  out  1  one-cycle pulse coincident with done when remainder ≠ 0
- remaining  out  8  undispensed amount; valid from done until next acceptance
- refill  in  1  inventory refill strobe
- refill_sel  in  2  denomination to refill (encoding as coin_sel; 11 ignored)
- refill_count  in  8  coins added
- inv_hi, inv_mid, inv_lo  out  8 each  current inventory counts
- dispensed_total  out  16  running sum of coin values ejected since reset; wraps modulo 2^16

## Operation
- States: IDLE, SELECT, EJECT, RELEASE, FINISH.
- Reset values: state IDLE; busy, coin_req, done, shortfall = 0; coin_sel = 00; remaining = 0; dispensed_total = 0; inv_* = INV_INIT.
- IDLE: if change_valid = 1, capture rem ← change_amount, go to SELECT. change_valid in any other state is ignored.
- SELECT:
  - If rem = 0: go to FINISH.
  - Otherwise, choose the largest denomination d with d ≤ rem and inv_d > 0. Set coin_sel and go to EJECT.
  - If no denomination qualifies: go to FINISH with a shortfall.
- EJECT: coin_req = 1 until coin_ack is sampled high. On that edge:
  - coin_req ← 0
  - rem ← rem − d
  - inv_d ← inv_d − 1
  - dispensed_total ← dispensed_total + d
  - go to RELEASE.
- RELEASE: wait for coin_ack = 0, then go to SELECT. An ack held high for several cycles counts as one coin.
- FINISH: done = 1 for one cycle; shortfall = (rem ≠ 0); remaining ← rem; go to IDLE.
- Refill:
  - Accepted in any state; adds refill_count to the selected inventory, saturating at 255.
  - Refill and eject decrement on the same denomination in the same cycle: result is sat255(inv + refill_count − 1).
- Arithmetic: rem is 8-bit and never underflows, because d ≤ rem is checked.

## Timing
- change_valid at edge N → busy and SELECT at N+1 → coin_req = 1 at N+2.
- Minimum per coin: 3 cycles (SELECT, EJECT with same-cycle ack, RELEASE with ack already low).
- change_amount = 0 → done at N+2, with no coin_req.
- coin_req falls on the edge after coin_ack is sampled high.
- Hopper must not drop coin_ack before coin_req falls.
- busy falls together with the done pulse, i.e. it reads 0 in the FINISH cycle.
- Asynchronous reset mid-operation: coin_req, busy and done drop immediately. Inventory returns to INV_INIT. An in-flight coin is not counted.

## Configuration
- CHANGE_INVENTORY_EN defined: inventory tracking, refill ports, inv_* outputs and shortfall behave as above.
- CHANGE_INVENTORY_EN undefined:
  - Every denomination is always available.
  - refill* ports are ignored; inv_* are driven 0.
  - shortfall is never asserted; remaining is always 0 at done.

## Test plan
- Reset, change_amount = 27, ack responder answers in 1 cycle → coin_sel sequence HI, HI, MID, LO, LO. Then done = 1, shortfall = 0, inv_hi = 18, inv_mid = 19, inv_lo = 18, dispensed_total = 27.
- After reset, request 255 → 20×HI + 11×MID, remaining = 0. Then request 250 → 9×MID + 20×LO, done with shortfall = 1, remaining = 185, all inv_* = 0.
- refill_sel = HI, refill_count = 5 in the same cycle as an HI eject ack, with inv_hi = 20 → inv_hi = 24. Refill 250 onto 20 → inv_hi = 255.
- change_amount = 0 → done 2 cycles after acceptance, coin_req never asserted. A second change_valid while busy = 1 produces no extra done.
- coin_ack held high for 4 cycles during an eject → exactly one decrement. coin_req stays 0 until coin_ack falls and the next SELECT completes.
- rst_n asserted while coin_req = 1 → coin_req = 0 asynchronously. After release: IDLE, inv_* = 20, dispensed_total = 0.

Source files
------------

// File: rtl/vending_change_dispenser_if.sv
// vending_change_dispenser_if: change-request and coin-hopper handshake bundle.
// master = controller/hopper side, slave = dispenser side.
interface vending_change_dispenser_if;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       busy;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       coin_ack;
    logic       done;
    logic       shortfall;
    logic [7:0] remaining;
    modport master (
        output change_valid, change_amount, coin_ack,
        input  busy, coin_req, coin_sel, done, shortfall, remaining
    );
    modport slave (
        input  change_valid, change_amount, coin_ack,
        output busy, coin_req, coin_sel, done, shortfall, remaining
    );
endinterface

// File: rtl/vending_change_dispenser.sv
// vending_change_dispenser: greedy three-denomination coin return over a four-phase hopper handshake.
// Define CHANGE_INVENTORY_EN to enable per-denomination inventory, refill and shortfall reporting.
module vending_change_dispenser #(
    parameter logic [7:0] DEN_HI   = 8'd10,
    parameter logic [7:0] DEN_MID  = 8'd5,
    parameter logic [7:0] DEN_LO   = 8'd1,
    parameter logic [7:0] INV_INIT = 8'd20
) (
    input  logic                              clk,
    input  logic                              rst_n,
    vending_change_dispenser_if.slave         bus,
    input  logic                              refill,
    input  logic [1:0]                        refill_sel,
    input  logic [7:0]                        refill_count,
    output logic [7:0]                        inv_hi,
    output logic [7:0]                        inv_mid,
    output logic [7:0]                        inv_lo,
    output logic [15:0]                       dispensed_total
);
    typedef enum logic [2:0] {IDLE, SELECT, EJECT, RELEASE, FINISH} state_t;
    state_t     state, state_nx;
    logic [7:0] rem, remaining_q, den;
    logic [1:0] sel_q, sel_nx;
    logic [2:0] avail;
    logic       take;

    assign den  = sel_q == 2'b10 ? DEN_HI : sel_q == 2'b01 ? DEN_MID : DEN_LO;
    assign take = state == EJECT && bus.coin_ack;

`ifdef CHANGE_INVENTORY_EN
    logic [2:0][7:0] inv, inv_nx;
    logic [8:0]      s;
    // Refill and eject on the same slot combine before saturation.
    always_comb begin
        inv_nx = inv;
        s      = '0;
        for (int i = 0; i < 3; i++) begin
            s = {1'b0, inv[i]} + ((refill && refill_sel == 2'(i)) ? {1'b0, refill_count} : 9'd0)
                - 9'(take && sel_q == 2'(i));
            inv_nx[i] = s[8] ? 8'hff : s[7:0];
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) inv <= {3{INV_INIT}};
        else        inv <= inv_nx;
    assign avail = {|inv[2], |inv[1], |inv[0]};
    assign {inv_hi, inv_mid, inv_lo} = inv;
`else
    logic unused_refill;
    assign unused_refill = ^{refill, refill_sel, refill_count};
    assign avail = 3'b111;
    assign {inv_hi, inv_mid, inv_lo} = '0;
`endif

    always_comb begin
        state_nx = state;
        sel_nx   = sel_q;
        case (state)
            IDLE:    state_nx = bus.change_valid ? SELECT : IDLE;
            SELECT: begin
                if (rem == 8'd0)                 state_nx = FINISH;
                else if (avail[2] && rem >= DEN_HI)  begin sel_nx = 2'b10; state_nx = EJECT; end
                else if (avail[1] && rem >= DEN_MID) begin sel_nx = 2'b01; state_nx = EJECT; end
                else if (avail[0] && rem >= DEN_LO)  begin sel_nx = 2'b00; state_nx = EJECT; end
                else                                 state_nx = FINISH;
            end
            EJECT:   state_nx = bus.coin_ack ? RELEASE : EJECT;
            RELEASE: state_nx = bus.coin_ack ? RELEASE : SELECT;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state           <= IDLE;
            sel_q           <= 2'b00;
            rem             <= '0;
            remaining_q     <= '0;
            dispensed_total <= '0;
        end else begin
            state <= state_nx;
            sel_q <= sel_nx;
            if (state == IDLE && bus.change_valid) rem <= bus.change_amount;
            else if (take)                         rem <= rem - den;
            if (take) dispensed_total <= dispensed_total + {8'd0, den};
            // Latch the remainder on entry to FINISH so it is valid during done.
            if (state == SELECT && state_nx == FINISH) remaining_q <= rem;
        end

    assign bus.busy      = state == SELECT || state == EJECT || state == RELEASE;
    assign bus.coin_req  = state == EJECT;
    assign bus.coin_sel  = sel_q;
    assign bus.done      = state == FINISH;
    assign bus.shortfall = state == FINISH && rem != 8'd0;
    assign bus.remaining = remaining_q;
endmodule

// File: tb/tb_vending_change_dispenser.sv
// tb_vending_change_dispenser: directed checks of the change dispenser with a scripted hopper responder.
module tb_vending_change_dispenser;
`ifdef CHANGE_INVENTORY_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif
    logic        clk, rst_n, refill;
    logic [1:0]  refill_sel;
    logic [7:0]  refill_count, inv_hi, inv_mid, inv_lo;
    logic [15:0] dispensed_total;
    int          passed = 0, total = 0;
    int          lat, ncoin, cnt_hi, cnt_mid, cnt_lo, extra, busy_n1, busy_done;
    logic [31:0] seq;
    logic        sf, req_in_hold, refill_hook, fin;
    logic [7:0]  rm;

    vending_change_dispenser_if bus ();

    vending_change_dispenser dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .refill(refill), .refill_sel(refill_sel), .refill_count(refill_count),
        .inv_hi(inv_hi), .inv_mid(inv_mid), .inv_lo(inv_lo),
        .dispensed_total(dispensed_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else passed++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic refill_pulse(input logic [1:0] s, input logic [7:0] c);
        @(negedge clk);
        refill = 1'b1; refill_sel = s; refill_count = c;
        @(negedge clk);
        refill = 1'b0;
    endtask

    // Issues one request and answers every coin_req, holding ack for 'hold' cycles.
    task automatic run(input logic [7:0] amt, input int hold, input bit dbl);
        int n, k;
        n = 0; k = 0; fin = 0; ncoin = 0; seq = 0; req_in_hold = 0;
        cnt_hi = 0; cnt_mid = 0; cnt_lo = 0; busy_n1 = 0; busy_done = 1;
        @(negedge clk);
        bus.change_valid = 1'b1; bus.change_amount = amt;
        @(negedge clk);
        bus.change_valid = 1'b0;
        while (!fin && n < 3000) begin
            n++;
            if (n == 2) bus.change_valid = 1'b0;
            if (n == 1) begin
                busy_n1 = int'(bus.busy);
                if (dbl) begin bus.change_valid = 1'b1; bus.change_amount = 8'd7; end
            end
            if (bus.done) begin
                fin = 1; lat = n; sf = bus.shortfall; rm = bus.remaining; busy_done = int'(bus.busy);
            end else if (bus.coin_ack) begin
                refill = 1'b0;
                if (bus.coin_req) req_in_hold = 1'b1;
                k--;
                if (k <= 0) bus.coin_ack = 1'b0;
            end else if (bus.coin_req) begin
                ncoin++;
                seq = {seq[29:0], bus.coin_sel};
                case (bus.coin_sel)
                    2'b10:   cnt_hi++;
                    2'b01:   cnt_mid++;
                    default: cnt_lo++;
                endcase
                bus.coin_ack = 1'b1; k = hold;
                if (refill_hook && bus.coin_sel == 2'b10) begin
                    refill = 1'b1; refill_sel = 2'b10; refill_count = 8'd5; refill_hook = 1'b0;
                end
            end
            if (!fin) @(negedge clk);
        end
        bus.change_valid = 1'b0;
        chk("done_seen", fin, 1);
    endtask

    task automatic watch_done(input int cyc, output int c);
        c = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (bus.done) c++;
        end
    endtask

    initial begin
        rst_n = 1'b0; refill = 1'b0; refill_sel = 2'b00; refill_count = 8'd0; refill_hook = 1'b0;
        bus.change_valid = 1'b0; bus.change_amount = 8'd0; bus.coin_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_req", bus.coin_req, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sf", bus.shortfall, 0);
        chk("rst_sel", bus.coin_sel, 0);
        chk("rst_rem", bus.remaining, 0);
        chk("rst_total", dispensed_total, 0);
        chk("rst_inv_hi", inv_hi, INV ? 20 : 0);
        chk("rst_inv_lo", inv_lo, INV ? 20 : 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(8'd27, 1, 0);
        chk("t27_seq", seq, 32'h290);
        chk("t27_ncoin", ncoin, 5);
        chk("t27_sf", sf, 0);
        chk("t27_rem", rm, 0);
        chk("t27_busy_done", busy_done, 0);
        chk("t27_total", dispensed_total, 27);
        chk("t27_inv_hi", inv_hi, INV ? 18 : 0);
        chk("t27_inv_mid", inv_mid, INV ? 19 : 0);
        chk("t27_inv_lo", inv_lo, INV ? 18 : 0);
        chk("t27_hold", req_in_hold, 0);

        do_reset();
        run(8'd255, 1, 0);
        chk("t255_hi", cnt_hi, INV ? 20 : 25);
        chk("t255_mid", cnt_mid, INV ? 11 : 1);
        chk("t255_lo", cnt_lo, 0);
        chk("t255_sf", sf, 0);
        chk("t255_rem", rm, 0);
        run(8'd250, 1, 0);
        chk("t250_hi", cnt_hi, INV ? 0 : 25);
        chk("t250_mid", cnt_mid, INV ? 9 : 0);
        chk("t250_lo", cnt_lo, INV ? 20 : 0);
        chk("t250_sf", sf, INV);
        chk("t250_rem", rm, INV ? 185 : 0);
        chk("t250_inv", {inv_hi, inv_mid, inv_lo}, 0);
        chk("t250_total", dispensed_total, INV ? 320 : 505);

        do_reset();
        refill_hook = 1'b1;
        run(8'd10, 1, 0);
        chk("rf_same_cycle", inv_hi, INV ? 24 : 0);
        chk("rf_total", dispensed_total, 10);
        do_reset();
        refill_pulse(2'b10, 8'd250);
        chk("rf_sat", inv_hi, INV ? 255 : 0);
        refill_pulse(2'b01, 8'd3);
        chk("rf_mid", inv_mid, INV ? 23 : 0);
        refill_pulse(2'b11, 8'd9);
        chk("rf_ignored", {inv_hi, inv_mid, inv_lo}, INV ? {8'd255, 8'd23, 8'd20} : 24'd0);

        run(8'd0, 1, 1);
        chk("z_lat", lat, 2);
        chk("z_ncoin", ncoin, 0);
        chk("z_busy_n1", busy_n1, 1);
        chk("z_sf", sf, 0);
        watch_done(8, extra);
        chk("z_extra_done", extra, 0);

        run(8'd1, 4, 0);
        chk("h_ncoin", ncoin, 1);
        chk("h_lo", cnt_lo, 1);
        chk("h_hold", req_in_hold, 0);
        chk("h_inv_lo", inv_lo, INV ? 19 : 0);
        chk("h_total", dispensed_total, 1);

        do_reset();
        @(negedge clk);
        bus.change_valid = 1'b1; bus.change_amount = 8'd10;
        @(negedge clk);
        bus.change_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.coin_req; i++) @(negedge clk);
        chk("ar_req_up", bus.coin_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", bus.coin_req, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ar_idle", bus.busy, 0);
        chk("ar_total", dispensed_total, 0);
        chk("ar_inv", {inv_hi, inv_mid, inv_lo}, INV ? {8'd20, 8'd20, 8'd20} : 24'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
